// File: rtl/vending_machine_multi.sv
// ============================================================================
//  Module      : vending_machine_multi
//  Description : Multi-item vending controller with bounded Rs5/Rs10 credit,
//                per-item pricing and Rs5 change payout over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vending_machine_multi #(
    parameter int                     N_ITEMS    = 4,
    parameter int                     CREDIT_W   = 8,
    parameter logic [N_ITEMS*8-1:0]   PRICES     = {8'd25, 8'd20, 8'd15, 8'd15},
    parameter int                     MAX_CREDIT = 45,
    parameter int                     AUTO_VEND  = 0,
    localparam int                    SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          COIN,
    input  logic [SEL_W-1:0]    SEL,
    input  logic                SEL_VALID,
    input  logic                CANCEL,
    input  logic                CHG_READY,
    output logic [N_ITEMS-1:0]  OPEN,
    output logic                CHANGE,
    output logic                CHG_VALID,
    output logic                REJECT,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0]   C_MAX_EXT = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] C_COIN5   = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] C_PRICE0  = CREDIT_W'(PRICES[7:0]);

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [N_ITEMS-1:0]   open_q, open_d;
    logic                 reject_q, reject_d;
    logic                 chg_valid_q, chg_valid_d;
    logic                 busy_q, busy_d;

    logic [CREDIT_W:0]    w_coin_sum;
    logic                 w_coin_legal;
    logic                 w_coin_ok;
    logic                 w_coin_rej;
    logic [CREDIT_W-1:0]  w_credit_n;
    logic [CREDIT_W-1:0]  w_sel_price;
    logic                 w_sel_in_range;
    logic                 w_auto;

    // Extra bit on the sum so an overflowing coin is caught rather than wrapped.
    assign w_coin_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(COIN);
    assign w_coin_legal = (COIN == 4'd5) || (COIN == 4'd10);
    assign w_coin_ok    = w_coin_legal && (w_coin_sum <= C_MAX_EXT);
    assign w_coin_rej   = (COIN != 4'd0) && !w_coin_ok;
    assign w_credit_n   = w_coin_ok ? w_coin_sum[CREDIT_W-1:0] : credit_q;
    assign w_auto       = (AUTO_VEND != 0) && (w_credit_n >= C_PRICE0);

    always_comb begin
        w_sel_price    = '0;
        w_sel_in_range = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (SEL == SEL_W'(i)) begin
                w_sel_in_range = 1'b1;
                w_sel_price    = CREDIT_W'(PRICES[i*8 +: 8]);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        open_d   = '0;
        reject_d = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                reject_d = w_coin_rej;
                credit_d = w_credit_n;
                state_d  = (w_credit_n != '0) ? S_COLLECT : S_IDLE;
                // Priority: cancel, then auto-vend, then explicit selection.
                if (CANCEL && (w_credit_n != '0)) begin
                    state_d = S_REFUND;
                end else if (w_auto) begin
                    open_d[0] = 1'b1;
                    credit_d  = w_credit_n - C_PRICE0;
                    state_d   = S_VEND;
                end else if (SEL_VALID) begin
                    if (w_sel_in_range && (w_credit_n >= w_sel_price)) begin
                        open_d   = N_ITEMS'(1) << SEL;
                        credit_d = w_credit_n - w_sel_price;
                        state_d  = S_VEND;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end

            S_VEND: begin
                reject_d = (COIN != 4'd0);
                state_d  = (credit_q != '0) ? S_REFUND : S_IDLE;
            end

            S_REFUND: begin
                reject_d = (COIN != 4'd0);
                if (chg_valid_q && CHG_READY) begin
                    if (credit_q <= C_COIN5) begin
                        credit_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        credit_d = credit_q - C_COIN5;
                    end
                end
            end

            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase

        chg_valid_d = (state_d == S_REFUND);
        busy_d      = (state_d == S_VEND) || (state_d == S_REFUND);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            open_q      <= '0;
            reject_q    <= 1'b0;
            chg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            open_q      <= open_d;
            reject_q    <= reject_d;
            chg_valid_q <= chg_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign OPEN      = open_q;
    assign REJECT    = reject_q;
    assign CREDIT    = credit_q;
    assign CHG_VALID = chg_valid_q;
    assign CHANGE    = chg_valid_q;
    assign BUSY      = busy_q;

endmodule

`default_nettype wire
